// File: rtl/instruktion_lader.sv
// instruktion_lader: boot loader that fills the instruction RAM before the CPU runs.
// It consumes a byte stream of the form  N[7:0] N[15:8] | payload words (little-endian),
// writes the words to RAM starting at address 0, and holds the CPU in reset until done.
// Optional build macro INSTRUKTION_LADER_PRUEFSUMME_EN: one trailer byte follows the image
// and must equal the XOR of all payload bytes, otherwise the load ends in FEHLER.
//
// Handshakes: a stream byte moves on a rising edge where ByteGueltig && ByteBereit;
// a RAM write completes on a rising edge where SchreibeRAM && RAMGeschrieben, and
// RAMDaten/RAMAdresse stay stable from the rise of SchreibeRAM until that edge.
module instruktion_lader #(
    parameter int WORDSIZE     = 32,
    parameter int WORDS        = 256,
    parameter int ADRESSBREITE = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [7:0]              ByteRein,
    input  logic                    ByteGueltig,
    output logic                    ByteBereit,
    output logic [WORDSIZE-1:0]     RAMDaten,
    output logic [ADRESSBREITE-1:0] RAMAdresse,
    output logic                    SchreibeRAM,
    input  logic                    RAMGeschrieben,
    output logic                    CPUReset,
    output logic                    Aktiv,
    output logic                    Fertig,
    output logic                    Fehler,
    output logic [2:0]              ZustandDbg
);

    localparam int BYTES = WORDSIZE / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BW-1:0]           LETZTES_BYTE = BW'(BYTES - 1);
    localparam logic [ADRESSBREITE-1:0] ADR_EINS     = ADRESSBREITE'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HEADER0   = 3'd1,
        HEADER1   = 3'd2,
        SAMMELN   = 3'd3,
        SCHREIBEN = 3'd4,
        PRUEFEN   = 3'd5,
        FERTIG    = 3'd6,
        FEHLER    = 3'd7
    } zustand_e;

    zustand_e                state_q, state_d;
    logic [15:0]             n_q, n_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [ADRESSBREITE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0]     data_q, data_d;
    logic                    byte_bereit_q, byte_bereit_d;
    logic                    schreibe_q, schreibe_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    aktiv_q, aktiv_d;
    logic                    fertig_q, fertig_d;
    logic                    fehler_q, fehler_d;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
    logic [7:0]              xor_q, xor_d;
`endif

    logic        byte_fire;
    logic [15:0] n_neu;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
        xor_d      = xor_q;
`endif
        byte_fire  = ByteGueltig && byte_bereit_q;
        n_neu      = {ByteRein, n_q[7:0]};

        case (state_q)
            IDLE, FERTIG, FEHLER: begin
                if (Start) begin
                    state_d = HEADER0;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
                    xor_d   = 8'h00;
`endif
                end
            end
            HEADER0: begin
                if (byte_fire) begin
                    n_d[7:0] = ByteRein;
                    state_d  = HEADER1;
                end
            end
            HEADER1: begin
                if (byte_fire) begin
                    n_d[15:8] = ByteRein;
                    if (n_neu == 16'd0) begin
                        state_d = FERTIG;
                    end else if (32'(n_neu) > 32'(WORDS)) begin
                        state_d = FEHLER;
                    end else begin
                        addr_d     = '0;
                        cnt_d      = '0;
                        byte_cnt_d = '0;
                        state_d    = SAMMELN;
                    end
                end
            end
            SAMMELN: begin
                if (byte_fire) begin
                    data_d[byte_cnt_q*8 +: 8] = ByteRein;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
                    xor_d = xor_q ^ ByteRein;
`endif
                    if (byte_cnt_q == LETZTES_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = SCHREIBEN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            SCHREIBEN: begin
                if (RAMGeschrieben) begin
                    // Address only advances after the write landed, so it wraps only on the last word
                    addr_d = addr_q + ADR_EINS;
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == n_q) begin
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
                        state_d = PRUEFEN;
`else
                        state_d = FERTIG;
`endif
                    end else begin
                        state_d = SAMMELN;
                    end
                end
            end
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
            PRUEFEN: begin
                if (byte_fire) begin
                    state_d = (ByteRein == xor_q) ? FERTIG : FEHLER;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it
        byte_bereit_d = (state_d == HEADER0) || (state_d == HEADER1) ||
                        (state_d == SAMMELN) || (state_d == PRUEFEN);
        schreibe_d    = (state_d == SCHREIBEN);
        aktiv_d       = (state_d == HEADER0) || (state_d == HEADER1) || (state_d == SAMMELN) ||
                        (state_d == SCHREIBEN) || (state_d == PRUEFEN);
        fertig_d      = (state_d == FERTIG);
        fehler_d      = (state_d == FEHLER);
        cpu_reset_d   = (state_d != FERTIG);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            n_q           <= '0;
            cnt_q         <= '0;
            byte_cnt_q    <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            byte_bereit_q <= 1'b0;
            schreibe_q    <= 1'b0;
            cpu_reset_q   <= 1'b1;
            aktiv_q       <= 1'b0;
            fertig_q      <= 1'b0;
            fehler_q      <= 1'b0;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
            xor_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            cnt_q         <= cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            byte_bereit_q <= byte_bereit_d;
            schreibe_q    <= schreibe_d;
            cpu_reset_q   <= cpu_reset_d;
            aktiv_q       <= aktiv_d;
            fertig_q      <= fertig_d;
            fehler_q      <= fehler_d;
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
            xor_q         <= xor_d;
`endif
        end
    end

    assign ByteBereit  = byte_bereit_q;
    assign RAMDaten    = data_q;
    assign RAMAdresse  = addr_q;
    assign SchreibeRAM = schreibe_q;
    assign CPUReset    = cpu_reset_q;
    assign Aktiv       = aktiv_q;
    assign Fertig      = fertig_q;
    assign Fehler      = fehler_q;
    assign ZustandDbg  = state_q;

endmodule

// File: tb/tb_instruktion_lader.sv
// Directed bench for instruktion_lader: byte driver, RAM responder with programmable
// acknowledge delay, expected-write queue and a final report.
module tb_instruktion_lader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  ByteRein = 8'h00;
    logic        ByteGueltig = 1'b0;
    logic        ByteBereit;
    logic [31:0] RAMDaten;
    logic [7:0]  RAMAdresse;
    logic        SchreibeRAM;
    logic        RAMGeschrieben = 1'b0;
    logic        CPUReset;
    logic        Aktiv;
    logic        Fertig;
    logic        Fehler;
    logic [2:0]  ZustandDbg;

    instruktion_lader #(.WORDSIZE(32), .WORDS(256), .ADRESSBREITE(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .ByteRein(ByteRein), .ByteGueltig(ByteGueltig), .ByteBereit(ByteBereit),
        .RAMDaten(RAMDaten), .RAMAdresse(RAMAdresse), .SchreibeRAM(SchreibeRAM),
        .RAMGeschrieben(RAMGeschrieben), .CPUReset(CPUReset), .Aktiv(Aktiv),
        .Fertig(Fertig), .Fehler(Fehler), .ZustandDbg(ZustandDbg)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];
    logic [39:0] exp_q [$];
    int          write_cnt = 0;
    int          ack_delay = 0;
    int          ack_ctr   = 0;
    logic [31:0] hold_data;
    logic [7:0]  hold_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM responder and scoreboard: holds off the acknowledge, checks stability, records writes
    always @(negedge Clock) begin
        if (!SchreibeRAM) begin
            ack_ctr        = 0;
            RAMGeschrieben = 1'b0;
        end else begin
            if (ack_ctr == 0) begin
                hold_data = RAMDaten;
                hold_addr = RAMAdresse;
            end else begin
                check("hold_data", 64'(RAMDaten), 64'(hold_data));
                check("hold_addr", 64'(RAMAdresse), 64'(hold_addr));
            end
            check("no_byte_in_write", 64'(ByteBereit), 64'd0);
            if (ack_ctr >= ack_delay) begin
                RAMGeschrieben = 1'b1;
                ram[RAMAdresse] = RAMDaten;
                write_cnt++;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("write_addr_data", 64'({RAMAdresse, RAMDaten}), 64'(exp_q.pop_front()));
                end
            end else begin
                RAMGeschrieben = 1'b0;
            end
            ack_ctr++;
        end
    end

    // driver tasks (all called at a falling edge)
    task automatic start_pulse();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        ByteRein    = b;
        ByteGueltig = 1'b1;
        while (!ByteBereit && t < 200) begin
            @(negedge Clock);
            t++;
        end
        check("byte_accept", 64'(ByteBereit), 64'd1);
        @(negedge Clock);
        ByteGueltig = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(Fertig || Fehler) && t < 500) begin
            @(negedge Clock);
            t++;
        end
        check("done_within_budget", 64'(t < 500), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // reset state
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_cpureset", 64'(CPUReset), 64'd1);
        check("rst_bytebereit", 64'(ByteBereit), 64'd0);
        check("rst_schreibe", 64'(SchreibeRAM), 64'd0);
        check("rst_fertig", 64'(Fertig), 64'd0);
        check("rst_fehler", 64'(Fehler), 64'd0);
        check("rst_aktiv", 64'(Aktiv), 64'd0);
        check("rst_adresse", 64'(RAMAdresse), 64'd0);
        check("rst_daten", 64'(RAMDaten), 64'd0);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        check("idle_cpureset", 64'(CPUReset), 64'd1);
        check("idle_bytebereit", 64'(ByteBereit), 64'd0);
        check("idle_fertig", 64'(Fertig), 64'd0);
        check("idle_state", 64'(ZustandDbg), 64'd0);
        check("idle_no_write", 64'(write_cnt), 64'd0);

        // two-word image, 1-cycle acknowledge
        ack_delay = 0;
        exp_q.push_back({8'd0, 32'h44332211});
        exp_q.push_back({8'd1, 32'hDDCCBBAA});
        start_pulse();
        check("t2_aktiv", 64'(Aktiv), 64'd1);
        send_byte(8'h02); send_byte(8'h00);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
        send_byte(8'h44);
`endif
        wait_done();
        check("t2_fertig", 64'(Fertig), 64'd1);
        check("t2_cpureset", 64'(CPUReset), 64'd0);
        check("t2_fehler", 64'(Fehler), 64'd0);
        check("t2_aktiv_end", 64'(Aktiv), 64'd0);
        check("t2_adresse", 64'(RAMAdresse), 64'd2);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t2_ram0", 64'(ram[0]), 64'h44332211);
        check("t2_ram1", 64'(ram[1]), 64'hDDCCBBAA);
        // a byte after the image is not consumed
        ByteRein = 8'h55; ByteGueltig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("t2_no_extra_byte", 64'(ByteBereit), 64'd0);
        end
        ByteGueltig = 1'b0;
        check("t2_still_fertig", 64'(Fertig), 64'd1);

        // same image, 5-cycle acknowledge delay, Start during load must be ignored
        ram[0] = 32'h0; ram[1] = 32'h0;
        ack_delay = 5;
        exp_q.push_back({8'd0, 32'h44332211});
        exp_q.push_back({8'd1, 32'hDDCCBBAA});
        start_pulse();
        check("t3_restart_cpureset", 64'(CPUReset), 64'd1);
        check("t3_restart_fertig", 64'(Fertig), 64'd0);
        send_byte(8'h02); send_byte(8'h00);
        start_pulse();
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
        send_byte(8'h44);
`endif
        wait_done();
        check("t3_fertig", 64'(Fertig), 64'd1);
        check("t3_adresse", 64'(RAMAdresse), 64'd2);
        check("t3_ram0", 64'(ram[0]), 64'h44332211);
        check("t3_ram1", 64'(ram[1]), 64'hDDCCBBAA);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        ack_delay = 0;

        // oversize header, then empty image
        wc = write_cnt;
        start_pulse();
        send_byte(8'h01); send_byte(8'h01);
        wait_done();
        check("t4_fehler", 64'(Fehler), 64'd1);
        check("t4_cpureset", 64'(CPUReset), 64'd1);
        check("t4_fertig", 64'(Fertig), 64'd0);
        check("t4_bytebereit", 64'(ByteBereit), 64'd0);
        check("t4_no_write", 64'(write_cnt), 64'(wc));
        start_pulse();
        check("t4_fehler_cleared", 64'(Fehler), 64'd0);
        send_byte(8'h00); send_byte(8'h00);
        wait_done();
        check("t4_empty_fertig", 64'(Fertig), 64'd1);
        check("t4_empty_fehler", 64'(Fehler), 64'd0);
        check("t4_empty_cpureset", 64'(CPUReset), 64'd0);
        check("t4_empty_no_write", 64'(write_cnt), 64'(wc));

        // asynchronous reset in the middle of word 1
        ram[0] = 32'h0;
        ram[1] = 32'hDEADBEEF;
        exp_q.push_back({8'd0, 32'h44332211});
        start_pulse();
        send_byte(8'h02); send_byte(8'h00);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        send_byte(8'hAA); send_byte(8'hBB);
        Reset = 1'b0;
        #1;
        check("t5_cpureset", 64'(CPUReset), 64'd1);
        check("t5_aktiv", 64'(Aktiv), 64'd0);
        check("t5_state_idle", 64'(ZustandDbg), 64'd0);
        check("t5_bytebereit", 64'(ByteBereit), 64'd0);
        check("t5_ram0", 64'(ram[0]), 64'h44332211);
        check("t5_ram1", 64'(ram[1]), 64'hDEADBEEF);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

`ifdef INSTRUKTION_LADER_PRUEFSUMME_EN
        // checksum trailer: good then bad
        exp_q.push_back({8'd0, 32'h08040201});
        start_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send4(8'h01, 8'h02, 8'h04, 8'h08);
        send_byte(8'h0F);
        wait_done();
        check("t6_good_fertig", 64'(Fertig), 64'd1);
        check("t6_good_fehler", 64'(Fehler), 64'd0);
        exp_q.push_back({8'd0, 32'h08040201});
        start_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send4(8'h01, 8'h02, 8'h04, 8'h08);
        send_byte(8'h0E);
        wait_done();
        check("t6_bad_fehler", 64'(Fehler), 64'd1);
        check("t6_bad_cpureset", 64'(CPUReset), 64'd1);
        check("t6_bad_ram0", 64'(ram[0]), 64'h08040201);
`else
        // single-word image: address ends at 1
        exp_q.push_back({8'd0, 32'h08040201});
        start_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send4(8'h01, 8'h02, 8'h04, 8'h08);
        wait_done();
        check("t6_fertig", 64'(Fertig), 64'd1);
        check("t6_adresse", 64'(RAMAdresse), 64'd1);
        check("t6_ram0", 64'(ram[0]), 64'h08040201);
`endif
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
